hazard_ctrl: RTL

- Hazard and stall controller for the 5-stage pipelined ARM core.
- Drives the stall and flush enables of the F/D, D/E and E/M pipeline registers, and the E-stage forwarding selects.
- Sequences multi-cycle multiplies held in Execute.
- Sits beside the datapath and is fed by decoded register addresses and control bits from the D, E, M and W stages.

---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_ctrl: hazard/stall controller for the 5-stage ARM pipeline.       |
// | Forwarding, load-use stalls, multi-cycle multiply sequencing, perf       |
// | counters (optional, enabled by HAZARD_PERF_CNT_EN).                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  RA1E,
    input  logic [3:0]  RA2E,
    input  logic [3:0]  WA3E,
    input  logic [3:0]  WA3M,
    input  logic [3:0]  WA3W,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MulStartE,
    input  logic        BranchTakenE,
    input  logic        PCWrPendingF,
    input  logic        PCSrcW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        MulBusy,
    output logic [15:0] LdStallCnt,
    output logic [15:0] BrFlushCnt,
    output logic [15:0] MulStallCnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] c_cnt_init = 4'(MUL_CYCLES - 2);

    state_t     r_state;
    logic [3:0] r_cnt;

    logic w_lwstall;
    logic w_lw_eff;
    logic w_mul_start;
    logic w_mulstall;

    // M-stage result is younger than W, so it wins; r15 is the PC and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra,
        input logic       we_m,
        input logic [3:0] wa_m,
        input logic       we_w,
        input logic [3:0] wa_w
    );
        if (we_m && (ra == wa_m) && (ra != 4'd15))
            return 2'b10;
        else if (we_w && (ra == wa_w) && (ra != 4'd15))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_lwstall   = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
        w_mul_start = (r_state == S_IDLE) & MulStartE & ~BranchTakenE;
        w_mulstall  = ~reset & (w_mul_start | ((r_state == S_BUSY) & (r_cnt != 4'd0)));
        // A taken branch squashes the dependent instruction, so no load-use stall.
        w_lw_eff    = ~reset & w_lwstall & ~BranchTakenE;

        ForwardAE = reset ? 2'b00 : fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
        ForwardBE = reset ? 2'b00 : fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);

        StallF  = w_lw_eff | w_mulstall | (~reset & PCWrPendingF);
        StallD  = w_lw_eff | w_mulstall;
        StallE  = w_mulstall;
        FlushD  = ~reset & (BranchTakenE | PCWrPendingF | PCSrcW);
        FlushE  = (~reset & BranchTakenE) | (w_lw_eff & ~w_mulstall);
        FlushM  = w_mulstall;
        MulBusy = ~reset & (r_state == S_BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mul_start) begin
                        r_state <= S_BUSY;
                        r_cnt   <= c_cnt_init;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0)
                        r_cnt <= r_cnt - 4'd1;
                    else
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_ld_cnt;
    logic [15:0] r_br_cnt;
    logic [15:0] r_mul_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld_cnt  <= 16'h0000;
            r_br_cnt  <= 16'h0000;
            r_mul_cnt <= 16'h0000;
        end else begin
            if (w_lw_eff && (r_ld_cnt != 16'hFFFF))
                r_ld_cnt <= r_ld_cnt + 16'd1;
            if (BranchTakenE && (r_br_cnt != 16'hFFFF))
                r_br_cnt <= r_br_cnt + 16'd1;
            if (w_mulstall && (r_mul_cnt != 16'hFFFF))
                r_mul_cnt <= r_mul_cnt + 16'd1;
        end
    end

    assign LdStallCnt  = r_ld_cnt;
    assign BrFlushCnt  = r_br_cnt;
    assign MulStallCnt = r_mul_cnt;
`else
    assign LdStallCnt  = 16'h0000;
    assign BrFlushCnt  = 16'h0000;
    assign MulStallCnt = 16'h0000;
`endif

endmodule
`default_nettype wire
